// File: rtl/sr_button_driver.sv
// sr_button_driver: command front end for the gated SR latch.
//
// Turns two raw, bouncing pushbuttons into clean, registered en/s/r command
// pulses. Each button is synchronised (two flops), debounced and then
// rising-edge detected. An arbiter guarantees the latch never sees s=r=1
// with en=1; simultaneous set/reset requests are dropped and flagged.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous, active-high reset
//   btn_set   - raw asynchronous set button, active high
//   btn_reset - raw asynchronous reset button, active high
//   en        - latch enable, registered
//   s         - latch set input, registered
//   r         - latch reset input, registered
//   busy      - high whenever the command FSM is not idle
//   conflict  - one-cycle pulse: simultaneous set/reset requests dropped
module sr_button_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  output logic en,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]    PulseLast = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSet, StRst, StGap} state_e;

  // Bit 0 carries the set button, bit 1 the reset button throughout.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d, deb_prev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       req;

  state_e          state_q, state_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [1:0]      pend_q, pend_d;
  logic            en_q, en_d, s_q, s_d, r_q, r_d;
  logic            conflict_q, conflict_d;

  assign btn_raw = {btn_reset, btn_set};

  // Debounce: the level must differ from the debounced value for
  // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DbLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign req = deb_q & ~deb_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  // Command FSM. New requests always fold into the pending flags first, so
  // in idle a request arriving this cycle is arbitrated alongside held ones.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    pend_d     = pend_q | req;
    conflict_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (pend_d[0] && pend_d[1]) begin
          conflict_d = 1'b1;
          pend_d     = '0;
        end else if (pend_d[0]) begin
          state_d   = StSet;
          pend_d[0] = 1'b0;
          pcnt_d    = '0;
        end else if (pend_d[1]) begin
          state_d   = StRst;
          pend_d[1] = 1'b0;
          pcnt_d    = '0;
        end
      end
      StSet, StRst: begin
        if (pcnt_q == PulseLast) begin
          state_d = StGap;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Outputs are registered from the next state so they align with it.
    en_d = (state_d == StSet) || (state_d == StRst);
    s_d  = (state_d == StSet);
    r_d  = (state_d == StRst);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pcnt_q     <= '0;
      pend_q     <= '0;
      en_q       <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign en       = en_q;
  assign s        = s_q;
  assign r        = r_q;
  assign busy     = (state_q != StIdle);
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_button_driver.sv
module tb_sr_button_driver;

  localparam int DB = 4;
  localparam int PC = 2;

  logic clk = 1'b0;
  logic rst, btn_set, btn_reset;
  logic en, s, r, busy, conflict;

  int total = 0;
  int bad   = 0;

  sr_button_driver #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (20),
    .PULSE_CYCLES   (PC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_set  (btn_set),
    .btn_reset(btn_reset),
    .en       (en),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  // Reference model: a raw-level history window per button decides when the
  // debounced level flips; commands are a countdown of busy cycles.
  bit hist [2][DB+2];  // [i][0] = newest raw sample seen at a clock edge
  bit m_deb [2];
  bit m_prev [2];
  bit pend [2];
  int left;            // remaining busy cycles: PC pulse cycles + 1 gap
  bit kind_s;
  bit e_conflict;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DB + 2; j++) hist[i][j] = 1'b0;
      m_deb[i]  = 1'b0;
      m_prev[i] = 1'b0;
      pend[i]   = 1'b0;
    end
    left       = 0;
    kind_s     = 1'b0;
    e_conflict = 1'b0;
  endtask

  task automatic model_step(input bit rs, input bit bs, input bit br);
    bit req [2];
    bit all_diff;
    if (rs) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      req[i]    = m_deb[i] & ~m_prev[i];
      m_prev[i] = m_deb[i];
      // Synchronised level seen now is the raw sample from two edges back.
      all_diff = 1'b1;
      for (int j = 1; j <= DB; j++) if (hist[i][j] == m_deb[i]) all_diff = 1'b0;
      if (all_diff) m_deb[i] = ~m_deb[i];
      for (int j = DB + 1; j >= 1; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = (i == 0) ? bs : br;
    end
    e_conflict = 1'b0;
    pend[0] = pend[0] | req[0];
    pend[1] = pend[1] | req[1];
    if (left > 0) begin
      left--;
    end else if (pend[0] && pend[1]) begin
      e_conflict = 1'b1;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else if (pend[0]) begin
      left = PC + 1; kind_s = 1'b1; pend[0] = 1'b0;
    end else if (pend[1]) begin
      left = PC + 1; kind_s = 1'b0; pend[1] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit rs, input bit bs, input bit br);
    bit e_en;
    @(negedge clk);
    rst = rs; btn_set = bs; btn_reset = br;
    @(posedge clk);
    model_step(rs, bs, br);
    #1;
    e_en = (left > 1);
    chk("en", en, e_en);
    chk("s", s, e_en & kind_s);
    chk("r", r, e_en & ~kind_s);
    chk("busy", busy, left > 0);
    chk("conflict", conflict, e_conflict);
    chk("s_and_r_never", s & r, 1'b0);
    chk("sr_needs_en", (s | r) & ~en, 1'b0);
    chk("conflict_vs_en", conflict & en, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; btn_set = 1'b0; btn_reset = 1'b0;
    model_reset();

    // Reset held with both buttons high
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b1);
    idle_n(15);

    // Clean set press
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0);
    idle_n(15);

    // Bouncing set press
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0);
    idle_n(15);

    // Short reset glitch
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);
    idle_n(15);

    // Simultaneous presses
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b1);
    idle_n(15);

    // Reset request queued behind an active set command
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b1);
    idle_n(15);

    // Same, but aborted by rst while the set pulse is on
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    idle_n(20);

    // Random presses of varying length, occasional reset
    for (int it = 0; it < 400; it++) begin
      bit bs, br, rs;
      int len;
      bs  = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      rs  = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) cyc(rs && (k == 0), bs, br);
    end
    idle_n(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
